// File: rtl/pe_block_stream.sv
// Streaming BLOCK_NUM x ARRAY_NUM signed MAC grid with a systolic weight
// path, a job FSM and a shift/saturate output stage held under backpressure.
module pe_block_stream #(
  parameter int ARRAY_NUM = 3,
  parameter int BLOCK_NUM = 3,
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 24,
  parameter int SHIFT_W   = 5
) (
  input  logic                                iClk,
  input  logic                                iRst,
  input  logic                                iStart,
  input  logic [15:0]                         iCfgAccLen,
  input  logic [SHIFT_W-1:0]                  iCfgShift,
  input  logic                                iValid,
  output logic                                oReady,
  input  logic [DATA_W*ARRAY_NUM*BLOCK_NUM-1:0] iData,
  input  logic [DATA_W-1:0]                   iWeight,
  output logic                                oBusy,
  output logic                                oValid,
  input  logic                                iReady,
  output logic [DATA_W*ARRAY_NUM*BLOCK_NUM-1:0] oResult
);

  localparam int PE_N = ARRAY_NUM * BLOCK_NUM;
  localparam int WP   = (BLOCK_NUM > 1) ? BLOCK_NUM - 1 : 1;
  localparam logic signed [ACC_W-1:0] SMAX =
    ACC_W'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] SMIN = -SMAX - 1;

  typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

  state_t state_q, state_d;
  logic [15:0]        len_q;
  logic [SHIFT_W-1:0] shift_q;
  logic [31:0]        t_q;
  logic [DATA_W-1:0]  wp_q [WP];
  logic [DATA_W-1:0]  wb   [BLOCK_NUM];

  logic signed [ACC_W-1:0]    acc_q [PE_N];
  logic signed [ACC_W-1:0]    acc_d [PE_N];
  logic signed [ACC_W-1:0]    sh    [PE_N];
  logic signed [2*DATA_W-1:0] prod  [PE_N];
  logic [DATA_W*PE_N-1:0]     res_q, res_d;

  logic fire, last, start;

  assign start = (state_q == IDLE) & iStart;
  assign fire  = (state_q == RUN) & iValid;
  assign last  = (t_q == 32'(len_q) + 32'(BLOCK_NUM) - 32'd2);

  // Block b sees the weight of beat t-b; stage 0 masks beats past L.
  always_comb begin
    wb[0] = (t_q < 32'(len_q)) ? iWeight : '0;
    for (int b = 1; b < BLOCK_NUM; b++) begin
      wb[b] = wp_q[b-1];
    end
  end

  always_comb begin
    for (int k = 0; k < PE_N; k++) begin
      prod[k]  = $signed(iData[k*DATA_W +: DATA_W])
               * $signed(wb[k/ARRAY_NUM]);
      acc_d[k] = acc_q[k];
      if (fire
          && t_q >= 32'(k / ARRAY_NUM)
          && t_q <  32'(k / ARRAY_NUM) + 32'(len_q)) begin
        acc_d[k] = acc_q[k] + ACC_W'(prod[k]);
      end
    end
  end

  always_comb begin
    res_d = '0;
    for (int k = 0; k < PE_N; k++) begin
      sh[k] = acc_d[k] >>> shift_q;
      if (sh[k] > SMAX) begin
        res_d[k*DATA_W +: DATA_W] = DATA_W'(SMAX);
      end else if (sh[k] < SMIN) begin
        res_d[k*DATA_W +: DATA_W] = DATA_W'(SMIN);
      end else begin
        res_d[k*DATA_W +: DATA_W] = DATA_W'(sh[k]);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    oReady  = 1'b0;
    oValid  = 1'b0;
    oBusy   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (iStart) state_d = RUN;
      end
      RUN: begin
        oReady = 1'b1;
        oBusy  = 1'b1;
        if (fire && last) state_d = OUT;
      end
      OUT: begin
        oValid = 1'b1;
        oBusy  = 1'b1;
        if (iReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= IDLE;
      len_q   <= '0;
      shift_q <= '0;
      t_q     <= '0;
      res_q   <= '0;
      for (int i = 0; i < WP; i++) wp_q[i] <= '0;
      for (int k = 0; k < PE_N; k++) acc_q[k] <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        len_q   <= (iCfgAccLen == 16'd0) ? 16'd1 : iCfgAccLen;
        shift_q <= iCfgShift;
        t_q     <= '0;
        for (int i = 0; i < WP; i++) wp_q[i] <= '0;
        for (int k = 0; k < PE_N; k++) acc_q[k] <= '0;
      end else if (fire) begin
        t_q     <= t_q + 32'd1;
        wp_q[0] <= wb[0];
        for (int i = 1; i < WP; i++) wp_q[i] <= wp_q[i-1];
        for (int k = 0; k < PE_N; k++) acc_q[k] <= acc_d[k];
        if (last) res_q <= res_d;
      end
    end
  end

  assign oResult = res_q;

endmodule

// File: tb/tb_pe_block_stream.sv
// Directed self-checking bench for pe_block_stream (default parameters).
module tb_pe_block_stream;

  localparam int PW = 72;

  logic          iClk = 1'b0;
  logic          iRst;
  logic          iStart;
  logic [15:0]   iCfgAccLen;
  logic [4:0]    iCfgShift;
  logic          iValid;
  logic          oReady;
  logic [PW-1:0] iData;
  logic [7:0]    iWeight;
  logic          oBusy;
  logic          oValid;
  logic          iReady;
  logic [PW-1:0] oResult;

  int n_chk  = 0;
  int n_fail = 0;

  pe_block_stream dut (
    .iClk       (iClk),
    .iRst       (iRst),
    .iStart     (iStart),
    .iCfgAccLen (iCfgAccLen),
    .iCfgShift  (iCfgShift),
    .iValid     (iValid),
    .oReady     (oReady),
    .iData      (iData),
    .iWeight    (iWeight),
    .oBusy      (oBusy),
    .oValid     (oValid),
    .iReady     (iReady),
    .oResult    (oResult)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [PW-1:0] obs,
                     input logic [PW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] rep(input logic [7:0] v);
    logic [PW-1:0] r;
    for (int k = 0; k < 9; k++) r[k*8 +: 8] = v;
    return r;
  endfunction

  function automatic logic [PW-1:0] ramp(input int m);
    logic [PW-1:0] r;
    for (int k = 0; k < 9; k++) r[k*8 +: 8] = 8'(m * (k + 1));
    return r;
  endfunction

  function automatic logic [PW-1:0] blk(input int b, input logic [7:0] v);
    logic [PW-1:0] r;
    r = '0;
    for (int k = 0; k < 9; k++) if (k / 3 == b) r[k*8 +: 8] = v;
    return r;
  endfunction

  task automatic start(input logic [15:0] len, input logic [4:0] s);
    iStart = 1'b1; iCfgAccLen = len; iCfgShift = s;
    @(negedge iClk);
    iStart = 1'b0;
  endtask

  task automatic beat(input logic [PW-1:0] d, input logic [7:0] w);
    chk("beat_ready", PW'(oReady), PW'(1));
    iData = d; iWeight = w; iValid = 1'b1;
    @(negedge iClk);
    iValid = 1'b0;
  endtask

  task automatic run_t2();
    start(16'd4, 5'd1);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) chk("t2_pre_valid", PW'(oValid), PW'(0));
      beat(ramp(1), (i < 4) ? 8'(i + 1) : 8'd9);
    end
    chk("t2_valid", PW'(oValid), PW'(1));
    chk("t2_res", oResult, ramp(5));
    @(negedge iClk);
  endtask

  initial begin
    iRst = 1'b1; iStart = 1'b0; iCfgAccLen = '0; iCfgShift = '0;
    iValid = 1'b0; iData = '0; iWeight = '0; iReady = 1'b1;
    repeat (2) @(negedge iClk);
    chk("rst_ready", PW'(oReady), PW'(0));
    chk("rst_busy", PW'(oBusy), PW'(0));
    chk("rst_valid", PW'(oValid), PW'(0));
    chk("rst_res", oResult, '0);
    iRst = 1'b0;
    @(negedge iClk);

    // L=1: each block sees weight 3 once
    start(16'd1, 5'd0);
    chk("t1_busy", PW'(oBusy), PW'(1));
    beat(rep(8'd2), 8'd3);
    beat(rep(8'd2), 8'd0);
    chk("t1_pre_valid", PW'(oValid), PW'(0));
    beat(rep(8'd2), 8'd0);
    chk("t1_valid", PW'(oValid), PW'(1));
    chk("t1_res", oResult, rep(8'd6));
    @(negedge iClk);
    chk("t1_idle_valid", PW'(oValid), PW'(0));

    run_t2();

    // saturation high then low
    start(16'd2, 5'd0);
    beat(rep(8'd127), 8'd127);
    beat(rep(8'd127), 8'd127);
    beat(rep(8'd127), 8'd0);
    beat(rep(8'd127), 8'd0);
    chk("t3_sat_hi", oResult, rep(8'd127));
    @(negedge iClk);
    start(16'd2, 5'd0);
    beat(rep(8'd127), 8'h80);
    beat(rep(8'd127), 8'h80);
    beat(rep(8'd127), 8'd0);
    beat(rep(8'd127), 8'd0);
    chk("t3_sat_lo", oResult, rep(8'h80));
    @(negedge iClk);

    // skew and masking of late weights
    start(16'd2, 5'd0);
    beat(blk(0, 8'd7), 8'd1);
    beat(blk(1, 8'd7), 8'd0);
    beat(blk(2, 8'd7), 8'd50);
    beat('0, 8'd50);
    chk("t4_skew", oResult, rep(8'd7));
    @(negedge iClk);

    // bubbles and output backpressure
    iReady = 1'b0;
    start(16'd4, 5'd1);
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 3)) begin
        iData = rep(8'hAA); iWeight = 8'h55;
        @(negedge iClk);
      end
      beat(ramp(1), (i < 4) ? 8'(i + 1) : 8'd9);
    end
    for (int j = 0; j < 5; j++) begin
      chk("t5_valid", PW'(oValid), PW'(1));
      chk("t5_ready", PW'(oReady), PW'(0));
      chk("t5_hold", oResult, ramp(5));
      iStart = (j == 2);
      @(negedge iClk);
    end
    iStart = 1'b0;
    iReady = 1'b1;
    @(negedge iClk);
    chk("t5_done_valid", PW'(oValid), PW'(0));
    chk("t5_done_busy", PW'(oBusy), PW'(0));
    @(negedge iClk);
    chk("t5_no_job", PW'(oBusy), PW'(0));
    chk("t5_keep", oResult, ramp(5));

    // reset mid-job
    start(16'd4, 5'd1);
    beat(ramp(1), 8'd1);
    beat(ramp(1), 8'd2);
    iRst = 1'b1;
    @(negedge iClk);
    iRst = 1'b0;
    chk("t6_busy", PW'(oBusy), PW'(0));
    chk("t6_valid", PW'(oValid), PW'(0));
    chk("t6_res", oResult, '0);
    @(negedge iClk);
    run_t2();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
